// File: rtl/core_pkg.sv
// Shared core types: fetch-sequencer states and PC select encodings.
// Imported by the fetch path and the program counter.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fseq_state_t;

   localparam logic [1:0] PCSEL_SEQ = 2'b00;
   localparam logic [1:0] PCSEL_ABS = 2'b01;
   localparam logic [1:0] PCSEL_REL = 2'b11;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps the PC, issues one imem request per instruction,
// buffers the word for decode and merges execute redirects.
module fetch_sequencer
   import core_pkg::*;
#(
   parameter int N    = 8,
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            run,
   input  logic [N-1:0]    pc,
   output logic            pc_en,
   output logic [1:0]      pcsel,
   output logic [N-1:0]    targaddr,
   output logic            imem_req,
   output logic [N-1:0]    imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   input  logic            dec_ready,
   input  logic            redir_valid,
   input  logic [N-1:0]    redir_base,
   input  logic [N-1:0]    redir_offs,
   output logic            redir_ready
);

   fseq_state_t     state_q, state_d;
   logic            pend_q, pend_d;
   logic [N-1:0]    targ_q, targ_d;
   logic [XLEN-1:0] instr_q, instr_d;

   logic            accept;
   logic            redirect;
   logic [N-1:0]    redir_tgt;
   logic [N-1:0]    apply_tgt;
   fseq_state_t     exit_state;

   assign redir_ready = !pend_q;
   // No redirect may reach the PC while reset is held.
   assign accept      = redir_valid && !pend_q && !reset;
   assign redir_tgt   = redir_base + redir_offs;
   assign apply_tgt   = pend_q ? targ_q : redir_tgt;
   assign redirect    = pend_q || accept;
   assign exit_state  = run ? FETCH : IDLE;
   assign imem_addr   = pc;
   assign instr       = instr_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         targ_q  <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         targ_q  <= targ_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      targ_d  = targ_q;
      instr_d = instr_q;
      unique case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (run) state_d = FETCH;
         end
         FETCH: begin
            if (!imem_ack) begin
               if (accept) begin
                  pend_d = 1'b1;
                  targ_d = redir_tgt;
               end
            end else if (redirect) begin
               pend_d  = 1'b0;
               state_d = exit_state;
            end else begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (accept || dec_ready) state_d = exit_state;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_en       = 1'b0;
      pcsel       = PCSEL_SEQ;
      targaddr    = '0;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_en    = 1'b1;
               pcsel    = PCSEL_ABS;
               targaddr = apply_tgt;
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               pc_en = 1'b1;
               if (redirect) begin
                  pcsel    = PCSEL_ABS;
                  targaddr = apply_tgt;
               end
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            // A redirect kills the younger held word even if decode is ready.
            if (accept) begin
               pc_en    = 1'b1;
               pcsel    = PCSEL_ABS;
               targaddr = redir_tgt;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the fetch loop.
module tb_fetch_sequencer;
   import core_pkg::*;

   localparam int N    = 8;
   localparam int XLEN = 32;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            run = 1'b0;
   logic [N-1:0]    pc;
   logic            pc_en;
   logic [1:0]      pcsel;
   logic [N-1:0]    targaddr;
   logic            imem_req;
   logic [N-1:0]    imem_addr;
   logic            imem_ack = 1'b0;
   logic [XLEN-1:0] imem_rdata = '0;
   logic            instr_valid;
   logic [XLEN-1:0] instr;
   logic            dec_ready = 1'b0;
   logic            redir_valid = 1'b0;
   logic [N-1:0]    redir_base = '0;
   logic [N-1:0]    redir_offs = '0;
   logic            redir_ready;

   fetch_sequencer #(.N(N), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .run(run), .pc(pc),
      .pc_en(pc_en), .pcsel(pcsel), .targaddr(targaddr),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .dec_ready(dec_ready),
      .redir_valid(redir_valid), .redir_base(redir_base),
      .redir_offs(redir_offs), .redir_ready(redir_ready)
   );

   always #5 clock = ~clock;

   // Environment program counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) pc <= '0;
      else if (pc_en) pc <= (pcsel == PCSEL_ABS) ? targaddr : pc + 1'b1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- stimulus side ----------------
   logic nx_reset = 1'b1, nx_run = 1'b0, nx_dec = 1'b0;
   bit   fixed_data = 0, spur = 0, force_ack = 0, wait_on = 0;
   int   lat_lo = 0, lat_hi = 0, cnt = 0;
   logic [N-1:0]    rq_base[$], rq_offs[$];
   logic [N-1:0]    fetched[$], abs_hist[$];
   logic [XLEN-1:0] mem [256];

   logic            s_req, s_ack, s_pc_en, s_iv, s_ready;
   logic [1:0]      s_pcsel;
   logic [N-1:0]    s_targ, s_addr;
   logic [XLEN-1:0] s_instr;

   task automatic step();
      @(posedge clock);
      #1;
      reset     = nx_reset;
      run       = nx_run;
      dec_ready = nx_dec;
      if (rq_base.size() > 0) begin
         redir_valid = 1'b1;
         redir_base  = rq_base[0];
         redir_offs  = rq_offs[0];
      end else begin
         redir_valid = 1'b0;
         redir_base  = N'($urandom);
         redir_offs  = N'($urandom);
      end
      #1;
      if (imem_req) begin
         if (!wait_on) begin
            wait_on = 1;
            cnt = $urandom_range(lat_hi, lat_lo);
         end
         imem_ack = (cnt == 0);
         if (imem_ack) begin
            wait_on    = 0;
            imem_rdata = fixed_data ? 32'h13 : mem[imem_addr];
         end else begin
            cnt--;
            imem_rdata = $urandom;
         end
      end else begin
         wait_on    = 0;
         imem_ack   = force_ack || (spur && $urandom_range(7, 0) == 0);
         imem_rdata = $urandom;
      end
      #2;
      s_req = imem_req; s_ack = imem_ack; s_pc_en = pc_en;
      s_iv = instr_valid; s_ready = redir_ready; s_pcsel = pcsel;
      s_targ = targaddr; s_addr = imem_addr; s_instr = instr;
      if (redir_valid && redir_ready && !reset) begin
         void'(rq_base.pop_front());
         void'(rq_offs.pop_front());
      end
      if (imem_req && imem_ack) fetched.push_back(imem_addr);
      if (pc_en && pcsel == PCSEL_ABS) abs_hist.push_back(targaddr);
      if (fixed_data && instr_valid && dec_ready)
         chk("straight_instr", instr, 32'h13);
   endtask

   task automatic do_reset();
      nx_reset = 1'b1;
      step();
      step();
      nx_reset = 1'b0;
   endtask

   task automatic until_req(input string nm);
      bit got = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_req) begin got = 1; break; end
      end
      chk({nm, "_req_seen"}, 32'(got), 32'd1);
   endtask

   task automatic until_iv(input string nm);
      bit got = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_iv) begin got = 1; break; end
      end
      chk({nm, "_valid_seen"}, 32'(got), 32'd1);
   endtask

   task automatic push_redir(input logic [N-1:0] b, input logic [N-1:0] o);
      rq_base.push_back(b);
      rq_offs.push_back(o);
   endtask

   // ---------------- reference model ----------------
   // The model tracks only: is a request outstanding, is a word waiting
   // for decode, which redirect targets are owed, and where the PC is.
   bit              m_fetch = 0, m_hold = 0, pw = 0;
   logic [N-1:0]    m_pc = '0, paddr = '0, tgt, atgt;
   logic [N-1:0]    m_owed[$];
   logic [XLEN-1:0] m_word = '0;
   int              act;
   bit              acc;

   always @(negedge clock) begin
      if (reset) begin
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_pc_en", 32'(pc_en), 32'd0);
         chk("rst_pcsel", 32'(pcsel), 32'd0);
         chk("rst_targ", 32'(targaddr), 32'd0);
         chk("rst_valid", 32'(instr_valid), 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_ready", 32'(redir_ready), 32'd1);
         m_fetch = 0; m_hold = 0; m_pc = '0; pw = 0;
         m_owed.delete();
      end else begin
         acc = redir_valid && (m_owed.size() == 0);
         tgt = redir_base + redir_offs;
         act = 0;
         atgt = '0;
         chk("redir_ready", 32'(redir_ready), 32'(m_owed.size() == 0));
         chk("imem_req", 32'(imem_req), 32'(m_fetch));
         chk("instr_valid", 32'(instr_valid), 32'(m_hold));
         if (m_fetch) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
         if (m_hold) chk("instr", instr, m_word);
         if (pw) chk("addr_stable", 32'(imem_addr), 32'(paddr));
         chk("pcsel_legal", 32'(pc_en && pcsel[1]), 32'd0);
         pw = imem_req && !imem_ack;
         paddr = imem_addr;
         if (m_fetch) begin
            if (!imem_ack) begin
               if (acc) m_owed.push_back(tgt);
            end else if (m_owed.size() > 0) begin
               act = 2; atgt = m_owed.pop_front(); m_fetch = run;
            end else if (acc) begin
               act = 2; atgt = tgt; m_fetch = run;
            end else begin
               act = 1; m_word = imem_rdata; m_fetch = 0; m_hold = 1;
            end
         end else if (m_hold) begin
            if (acc) begin
               act = 2; atgt = tgt; m_hold = 0; m_fetch = run;
            end else if (dec_ready) begin
               m_hold = 0; m_fetch = run;
            end
         end else begin
            if (m_owed.size() > 0) begin
               act = 2; atgt = m_owed.pop_front();
            end else if (acc) begin
               act = 2; atgt = tgt;
            end
            m_fetch = run;
         end
         chk("pc_en", 32'(pc_en), 32'(act != 0));
         chk("pcsel", 32'(pcsel), 32'(act == 2 ? PCSEL_ABS : PCSEL_SEQ));
         chk("targaddr", 32'(targaddr), 32'(act == 2 ? atgt : '0));
         if (act == 1) m_pc = m_pc + 1'b1;
         else if (act == 2) m_pc = atgt;
      end
   end

   // ---------------- scenarios ----------------
   logic [XLEN-1:0] held;
   logic [N-1:0]    haddr;
   bit              found;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // Straight-line fetch, one-cycle memory.
      nx_run = 1; nx_dec = 1; lat_lo = 1; lat_hi = 1; fixed_data = 1;
      do_reset();
      fetched.delete();
      repeat (16) step();
      chk("straight_count", 32'(fetched.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         if (fetched.size() > i) chk("straight_addr", 32'(fetched[i]), i);
      fixed_data = 0;

      // Decode stall in HOLD.
      lat_lo = 0; lat_hi = 0; nx_dec = 0;
      until_iv("stall");
      held  = s_instr;
      haddr = fetched[$];
      repeat (2) begin
         step();
         chk("stall_valid", 32'(s_iv), 32'd1);
         chk("stall_instr", s_instr, held);
         chk("stall_req", 32'(s_req), 32'd0);
         chk("stall_pc_en", 32'(s_pc_en), 32'd0);
      end
      nx_dec = 1;
      step();
      step();
      haddr = haddr + 1'b1;
      chk("stall_next_req", 32'(s_req), 32'd1);
      chk("stall_next_addr", 32'(s_addr), 32'(haddr));

      // Redirect while a fetch waits for its ack.
      lat_lo = 2; lat_hi = 2;
      do_reset();
      until_req("redir_fetch");
      push_redir(8'h10, 8'h04);
      step();
      chk("rf_accepted", 32'(rq_base.size()), 32'd0);
      step();
      chk("rf_ready", 32'(s_ready), 32'd0);
      chk("rf_ack", 32'(s_ack), 32'd1);
      chk("rf_pc_en", 32'(s_pc_en), 32'd1);
      chk("rf_pcsel", 32'(s_pcsel), 32'd1);
      chk("rf_targ", 32'(s_targ), 32'h14);
      step();
      chk("rf_no_deliver", 32'(s_iv), 32'd0);
      chk("rf_next_addr", 32'(s_addr), 32'h14);

      // Redirect and dec_ready together in HOLD, target wraps.
      lat_lo = 0; lat_hi = 0; nx_dec = 0;
      do_reset();
      until_iv("hold_redir");
      push_redir(8'hFE, 8'h05);
      nx_dec = 1;
      step();
      chk("hr_pc_en", 32'(s_pc_en), 32'd1);
      chk("hr_pcsel", 32'(s_pcsel), 32'd1);
      chk("hr_targ", 32'(s_targ), 32'h03);
      step();
      chk("hr_dropped", 32'(s_iv), 32'd0);
      chk("hr_next_addr", 32'(s_addr), 32'h03);

      // Two redirects back to back during a slow fetch.
      lat_lo = 3; lat_hi = 3;
      do_reset();
      until_req("b2b");
      abs_hist.delete();
      push_redir(8'h20, 8'h01);
      push_redir(8'h40, 8'h02);
      step();
      chk("b2b_first_taken", 32'(rq_base.size()), 32'd1);
      step();
      chk("b2b_blocked", 32'(s_ready), 32'd0);
      step();
      chk("b2b_first_targ", 32'(s_targ), 32'h21);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_req && s_addr == 8'h42) begin found = 1; break; end
      end
      chk("b2b_second_fetch", 32'(found), 32'd1);
      chk("b2b_hist_n", 32'(abs_hist.size()), 32'd2);
      if (abs_hist.size() == 2) chk("b2b_hist_1", 32'(abs_hist[1]), 32'h42);

      // Reset during a fetch, then a late ack while idle.
      do_reset();
      until_req("rst_mid");
      nx_reset = 1; nx_run = 0;
      step();
      chk("rm_req", 32'(s_req), 32'd0);
      chk("rm_pc_en", 32'(s_pc_en), 32'd0);
      nx_reset = 0; force_ack = 1;
      step();
      chk("rm_late_ack_req", 32'(s_req), 32'd0);
      chk("rm_late_ack_pc_en", 32'(s_pc_en), 32'd0);
      force_ack = 0;
      repeat (3) begin
         step();
         chk("rm_idle", 32'(s_req), 32'd0);
      end

      // Random traffic.
      lat_lo = 0; lat_hi = 3; spur = 1; nx_run = 1;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         nx_run   = ($urandom_range(7, 0) != 0);
         nx_dec   = ($urandom_range(2, 0) != 0);
         nx_reset = (c == 2000);
         if (rq_base.size() == 0 && $urandom_range(5, 0) == 0)
            push_redir(N'($urandom), N'($urandom));
         step();
      end
      nx_reset = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
